// File: rtl/reg_file_pkg.sv
// Shared defaults for the multi-port register file.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
//
// Holds the default geometry used by reg_file_mp and a helper that derives
// the byte-strobe width from a data width.
package reg_file_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_REG_AMOUNT = 32;
  localparam int DEF_RD_PORTS   = 2;
  localparam int DEF_STRB_WIDTH = DEF_DATA_WIDTH / 8;

  // One strobe bit per data byte.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-result scoreboard: one bit per register, set on issue, cleared on write.
// Latency: set/clear visible one cycle after the request edge; o_any is registered.
// Backpressure: none; requests are always accepted.
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_set, i_set_addr      mark a register pending
//   i_clr, i_clr_addr      clear a register's pending bit (write-back)
//   o_pending              registered pending bit per register
//   o_any                  registered OR of all pending bits
module reg_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_AMOUNT = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_set,
  input  logic [ADDR_WIDTH-1:0] i_set_addr,
  input  logic                  i_clr,
  input  logic [ADDR_WIDTH-1:0] i_clr_addr,
  output logic [REG_AMOUNT-1:0] o_pending,
  output logic                  o_any
);

  logic [REG_AMOUNT-1:0] r_pending;
  logic                  r_any;
  logic [REG_AMOUNT-1:0] w_next;

  // Set is applied after clear so a same-cycle set/clear to one index keeps
  // the bit pending. Indices outside the file never match any bit position.
  always_comb begin
    w_next = r_pending;
    for (int i = 0; i < REG_AMOUNT; i++) begin
      if (i_clr && (i_clr_addr == ADDR_WIDTH'(i))) w_next[i] = 1'b0;
      if (i_set && (i_set_addr == ADDR_WIDTH'(i))) w_next[i] = 1'b1;
    end
    if (ZERO_REG != 0) w_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_any     <= 1'b0;
    end else begin
      r_pending <= w_next;
      r_any     <= |w_next;
    end
  end

  assign o_pending = r_pending;
  assign o_any     = r_any;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-strobed writes, optional write
// bypass, optional hard-wired zero register and a pending-result scoreboard.
// Latency: reads combinational (0 cycles); writes and pending bits land at the next edge.
// Backpressure: none; every write and busy_set is accepted.
//
// Ports:
//   i_clk, i_rst_n                clock, synchronous active-low reset
//   w_enable/w_addr/w_data/w_strb write request with byte enables
//   busy_set/busy_addr            mark a register as having a result in flight
//   r_addr/r_data/r_busy          read ports, port p in slice p
//   busy_any                      registered OR of all pending bits
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_AMOUNT = DEF_REG_AMOUNT,
  parameter int RD_PORTS   = DEF_RD_PORTS,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           w_enable,
  input  logic [ADDR_WIDTH-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [strb_width(DATA_WIDTH)-1:0] w_strb,
  input  logic                           busy_set,
  input  logic [ADDR_WIDTH-1:0]          busy_addr,
  input  logic [RD_PORTS*ADDR_WIDTH-1:0] r_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0] r_data,
  output logic [RD_PORTS-1:0]            r_busy,
  output logic                           busy_any
);

  localparam int                  STRB_W   = strb_width(DATA_WIDTH);
  // One extra bit so REG_AMOUNT == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] LP_NREGS = (ADDR_WIDTH+1)'(REG_AMOUNT);

  logic [DATA_WIDTH-1:0] r_regs [REG_AMOUNT];
  logic [REG_AMOUNT-1:0] w_pending;
  logic                  w_wr_ok;

  // A write lands only on an implemented, writable index.
  assign w_wr_ok = w_enable
                && ({1'b0, w_addr} < LP_NREGS)
                && !((ZERO_REG != 0) && (w_addr == '0));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_AMOUNT; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < REG_AMOUNT; i++) begin
        if (w_addr == ADDR_WIDTH'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb[b]) r_regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Every write clears the pending bit, even with an all-zero strobe.
  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_AMOUNT (REG_AMOUNT),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_set      (busy_set),
    .i_set_addr (busy_addr),
    .i_clr      (w_enable),
    .i_clr_addr (w_addr),
    .o_pending  (w_pending),
    .o_any      (busy_any)
  );

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_stored;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_raddr = r_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Out-of-range indices and the zero register read as constant zero.
    assign w_valid = ({1'b0, w_raddr} < LP_NREGS)
                  && !((ZERO_REG != 0) && (w_raddr == '0));

    // Storage is masked while reset is held so reads are 0 even before the
    // first reset edge has cleared the array.
    assign w_stored = (w_valid && i_rst_n) ? r_regs[w_raddr] : '0;

    // Bypass merges the strobed bytes of the in-flight write; it stays live
    // during reset, where the merge base is the masked zero word.
    always_comb begin
      w_word = w_stored;
      if ((BYPASS != 0) && w_enable && w_valid && (w_raddr == w_addr)) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_strb[b]) w_word[b*8 +: 8] = w_data[b*8 +: 8];
        end
      end
    end

    assign r_data[p*DATA_WIDTH +: DATA_WIDTH] = w_word;
    // Pending flag is the registered bit only; a same-cycle clear is not forwarded.
    assign r_busy[p] = w_valid ? w_pending[w_raddr] : 1'b0;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default build, a no-bypass build and a
// 20-register build share one stimulus stream.
module tb_reg_file_mp;

  logic        clk;
  logic        rst_n;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [9:0]  r_addr;

  logic [63:0] d_rdata,  nb_rdata,  r20_rdata;
  logic [1:0]  d_rbusy,  nb_rbusy,  r20_rbusy;
  logic        d_any,    nb_any,    r20_any;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp20 [20];

  reg_file_mp u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .w_enable(w_enable), .w_addr(w_addr),
    .w_data(w_data), .w_strb(w_strb), .busy_set(busy_set), .busy_addr(busy_addr),
    .r_addr(r_addr), .r_data(d_rdata), .r_busy(d_rbusy), .busy_any(d_any)
  );

  reg_file_mp #(.BYPASS(0)) u_nobyp (
    .i_clk(clk), .i_rst_n(rst_n), .w_enable(w_enable), .w_addr(w_addr),
    .w_data(w_data), .w_strb(w_strb), .busy_set(busy_set), .busy_addr(busy_addr),
    .r_addr(r_addr), .r_data(nb_rdata), .r_busy(nb_rbusy), .busy_any(nb_any)
  );

  reg_file_mp #(.REG_AMOUNT(20)) u_r20 (
    .i_clk(clk), .i_rst_n(rst_n), .w_enable(w_enable), .w_addr(w_addr),
    .w_data(w_data), .w_strb(w_strb), .busy_set(busy_set), .busy_addr(busy_addr),
    .r_addr(r_addr), .r_data(r20_rdata), .r_busy(r20_rbusy), .busy_any(r20_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    w_enable = 1'b1;
    w_addr   = a;
    w_data   = d;
    w_strb   = s;
  endtask

  task automatic idle();
    w_enable = 1'b0;
    w_strb   = 4'h0;
    w_data   = '0;
    busy_set = 1'b0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    r_addr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0; w_enable = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
    busy_set = 1'b0; busy_addr = '0; r_addr = '0;

    // Reset state
    set_rd(5'd5, 5'd3);
    tick(); tick();
    check_eq("rst_rd0",  d_rdata[31:0],  32'h0);
    check_eq("rst_rd1",  d_rdata[63:32], 32'h0);
    check_eq("rst_busy", {30'd0, d_rbusy}, 32'h0);
    check_eq("rst_any",  {31'd0, d_any},  32'h0);
    rst_n = 1'b1;
    tick();

    // Full write then single-byte strobe
    drive_wr(5'd5, 32'hDEADBEEF, 4'hF); tick();
    drive_wr(5'd5, 32'h00001200, 4'h2); tick();
    idle();
    set_rd(5'd5, 5'd5);
    #1;
    check_eq("strb_rd0",     d_rdata[31:0],  32'hDEAD12EF);
    check_eq("strb_rd1_same", d_rdata[63:32], 32'hDEAD12EF);
    check_eq("strb_nobyp",   nb_rdata[31:0], 32'hDEAD12EF);

    // Same-cycle bypass vs. stored value
    set_rd(5'd7, 5'd5);
    drive_wr(5'd7, 32'h11223344, 4'hF);
    #1;
    check_eq("byp_new",   d_rdata[31:0],  32'h11223344);
    check_eq("nobyp_old", nb_rdata[31:0], 32'h00000000);
    tick(); idle(); #1;
    check_eq("nobyp_after", nb_rdata[31:0], 32'h11223344);

    // Partial bypass merges only the strobed byte
    set_rd(5'd5, 5'd7);
    drive_wr(5'd5, 32'h000000AA, 4'h1);
    #1;
    check_eq("byp_partial",   d_rdata[31:0],  32'hDEAD12AA);
    check_eq("nobyp_partial", nb_rdata[31:0], 32'hDEAD12EF);
    tick(); idle(); #1;
    check_eq("partial_stored", d_rdata[31:0], 32'hDEAD12AA);

    // Zero register: writes, bypass and busy ignored
    set_rd(5'd0, 5'd0);
    drive_wr(5'd0, 32'hFFFFFFFF, 4'hF);
    busy_set = 1'b1; busy_addr = 5'd0;
    #1;
    check_eq("zero_nobypass", d_rdata[31:0], 32'h0);
    tick(); idle(); #1;
    check_eq("zero_rd",   d_rdata[31:0],     32'h0);
    check_eq("zero_busy", {31'd0, d_rbusy[0]}, 32'h0);
    check_eq("zero_any",  {31'd0, d_any},    32'h0);

    // Scoreboard: set wins over same-cycle clear, data still written
    set_rd(5'd3, 5'd3);
    busy_set = 1'b1; busy_addr = 5'd3; tick();
    busy_set = 1'b0; #1;
    check_eq("sb_set",     {31'd0, d_rbusy[0]}, 32'h1);
    check_eq("sb_set_any", {31'd0, d_any},      32'h1);
    drive_wr(5'd3, 32'h00000033, 4'hF);
    busy_set = 1'b1; busy_addr = 5'd3;
    tick(); idle(); #1;
    check_eq("sb_setwins",  {31'd0, d_rbusy[0]}, 32'h1);
    check_eq("sb_setwins_dat", d_rdata[31:0],    32'h00000033);
    check_eq("sb_port_same", {31'd0, d_rbusy[1]}, 32'h1);
    // Zero-strobe write clears pending, keeps data; clear not forwarded in-cycle
    drive_wr(5'd3, 32'h00000044, 4'h0);
    #1;
    check_eq("sb_noforward", {31'd0, d_rbusy[0]}, 32'h1);
    tick(); idle(); #1;
    check_eq("sb_clr",      {31'd0, d_rbusy[0]}, 32'h0);
    check_eq("sb_clr_any",  {31'd0, d_any},      32'h0);
    check_eq("sb_strb0_dat", d_rdata[31:0],      32'h00000033);

    // Out-of-range index on the 20-register build
    drive_wr(5'd25, 32'h00000005, 4'hF);
    busy_set = 1'b1; busy_addr = 5'd25;
    set_rd(5'd25, 5'd25);
    tick(); idle(); #1;
    check_eq("oor_rd",       r20_rdata[31:0],        32'h0);
    check_eq("oor_busy",     {31'd0, r20_rbusy[0]},  32'h0);
    check_eq("oor_any",      {31'd0, r20_any},       32'h0);
    check_eq("inr_rd32",     d_rdata[31:0],          32'h00000005);
    check_eq("inr_busy32",   {31'd0, d_rbusy[0]},    32'h1);
    for (int i = 0; i < 20; i++) exp20[i] = 32'h0;
    exp20[3] = 32'h00000033;
    exp20[5] = 32'hDEAD12AA;
    exp20[7] = 32'h11223344;
    for (int i = 0; i < 20; i++) begin
      set_rd(5'd0, 5'(i));
      #1;
      check_eq($sformatf("r20_reg%0d", i), r20_rdata[63:32], exp20[i]);
    end

    // Reset with live state and pending bits
    for (int i = 1; i <= 4; i++) begin
      drive_wr(5'(i), 32'h100 + i, 4'hF); tick();
    end
    idle();
    busy_set = 1'b1; busy_addr = 5'd2; tick();
    busy_set = 1'b0; #1;
    check_eq("pre_rst_any", {31'd0, d_any}, 32'h1);
    set_rd(5'd4, 5'd1);
    rst_n = 1'b0;
    drive_wr(5'd1, 32'h0000CAFE, 4'hF);
    busy_set = 1'b1; busy_addr = 5'd4;
    #1;
    check_eq("rst_mask_rd",  d_rdata[31:0],  32'h0);
    check_eq("rst_bypass",   d_rdata[63:32], 32'h0000CAFE);
    check_eq("rst_nobyp",    nb_rdata[63:32], 32'h0);
    tick();
    rst_n = 1'b1; idle(); #1;
    check_eq("post_rst_discard", d_rdata[63:32], 32'h0);
    check_eq("post_rst_any",     {31'd0, d_any}, 32'h0);
    check_eq("post_rst_busy4",   {31'd0, d_rbusy[0]}, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      set_rd(5'(i), 5'd2);
      #1;
      check_eq($sformatf("post_rst_reg%0d", i), d_rdata[31:0], 32'h0);
    end
    check_eq("post_rst_busy2", {31'd0, d_rbusy[1]}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
